// File: rtl/data_mem_bhw_pkg.sv
// mem_pkg: access codes, dump FSM state encoding and the alignment rule
// shared by the data memory and its load extender.
`default_nettype none

package mem_pkg;

  localparam logic [2:0] BHW_B  = 3'b000;
  localparam logic [2:0] BHW_H  = 3'b001;
  localparam logic [2:0] BHW_W  = 3'b011;
  localparam logic [2:0] BHW_BU = 3'b100;
  localparam logic [2:0] BHW_HU = 3'b101;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_VALID = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Unlisted access codes are treated as word accesses.
  function automatic logic is_aligned(input logic [2:0] bhw, input logic [1:0] lane);
    case (bhw)
      BHW_B, BHW_BU: return 1'b1;
      BHW_H, BHW_HU: return ~lane[0];
      default:       return (lane == 2'b00);
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_bhw_if.sv
// data_mem_bhw_if: pipeline load/store port plus debug dump stream.
`default_nettype none

interface data_mem_bhw_if #(
  parameter int B = 32,
  parameter int W = 10
);
  logic         i_mem_read;
  logic         i_mem_write;
  logic [2:0]   i_bhw;
  logic [W-1:0] i_addr;
  logic [B-1:0] i_data;
  logic [B-1:0] o_data;
  logic         o_misaligned;
  logic         i_dump_start;
  logic         i_dump_ready;
  logic         o_dump_valid;
  logic [B-1:0] o_dump_data;
  logic [W-3:0] o_dump_addr;
  logic         o_dump_busy;
  logic         o_dump_done;

  modport master (
    output i_mem_read, i_mem_write, i_bhw, i_addr, i_data, i_dump_start, i_dump_ready,
    input  o_data, o_misaligned, o_dump_valid, o_dump_data, o_dump_addr, o_dump_busy, o_dump_done
  );

  modport slave (
    input  i_mem_read, i_mem_write, i_bhw, i_addr, i_data, i_dump_start, i_dump_ready,
    output o_data, o_misaligned, o_dump_valid, o_dump_data, o_dump_addr, o_dump_busy, o_dump_done
  );
endinterface

`default_nettype wire

// File: rtl/data_mem_bhw_load_ext.sv
// load_ext: selects the byte/halfword lane of a word and sign- or zero-extends it.
`default_nettype none

module load_ext
  import mem_pkg::*;
#(
  parameter int B = 32
) (
  input  logic [B-1:0] i_word,
  input  logic [1:0]   i_lane,
  input  logic [2:0]   i_bhw,
  output logic [B-1:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [B-1:0] w_shifted;

  assign w_shifted = i_word >> {i_lane, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = i_lane[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_result = i_word;
    case (i_bhw)
      BHW_B:   o_result = {{(B-8){w_byte[7]}}, w_byte};
      BHW_BU:  o_result = {{(B-8){1'b0}}, w_byte};
      BHW_H:   o_result = {{(B-16){w_half[15]}}, w_half};
      BHW_HU:  o_result = {{(B-16){1'b0}}, w_half};
      default: o_result = i_word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_bhw.sv
// data_mem_bhw: byte/half/word data memory with registered loads and an optional
// debug dump port built when DATA_MEM_DUMP_EN is defined.
`default_nettype none

module data_mem_bhw
  import mem_pkg::*;
#(
  parameter int B = 32,
  parameter int W = 10
) (
  input  logic           i_clk,
  input  logic           i_rst,
  data_mem_bhw_if.slave  bus
);

  localparam int DEPTH = 2 ** (W - 2);

  generate
    if (B != 32) begin : g_bad_width
      $error("data_mem_bhw supports only B = 32");
    end
  endgenerate

  logic [B-1:0] mem [DEPTH];

  logic [1:0]   w_lane;
  logic [W-3:0] w_idx;
  logic         w_aligned;
  logic         w_we;
  logic [3:0]   w_be;
  logic [B-1:0] w_wdata;
  logic [B-1:0] w_load;
  logic [B-1:0] r_data;
  logic         r_misaligned;

  assign w_lane    = bus.i_addr[1:0];
  assign w_idx     = bus.i_addr[W-1:2];
  assign w_aligned = is_aligned(bus.i_bhw, w_lane);
  assign w_we      = bus.i_mem_write && w_aligned;

  // Store data is replicated so the byte enables alone pick the lanes.
  always_comb begin
    w_be    = 4'hF;
    w_wdata = bus.i_data;
    case (bus.i_bhw)
      BHW_B, BHW_BU: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{bus.i_data[7:0]}};
      end
      BHW_H, BHW_HU: begin
        w_be    = 4'b0011 << w_lane;
        w_wdata = {2{bus.i_data[15:0]}};
      end
      default: begin
        w_be    = 4'hF;
        w_wdata = bus.i_data;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  load_ext #(.B(B)) u_load_ext (
    .i_word   (mem[w_idx]),
    .i_lane   (w_lane),
    .i_bhw    (bus.i_bhw),
    .o_result (w_load)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data       <= '0;
      r_misaligned <= 1'b0;
    end else begin
      if (bus.i_mem_read && w_aligned) r_data <= w_load;
      r_misaligned <= (bus.i_mem_read || bus.i_mem_write) && !w_aligned;
    end
  end

  assign bus.o_data       = r_data;
  assign bus.o_misaligned = r_misaligned;

`ifdef DATA_MEM_DUMP_EN
  localparam logic [W-3:0] C_LAST = {(W-2){1'b1}};

  logic [1:0]   r_state;
  logic [1:0]   w_next;
  logic [W-3:0] r_dump_idx;
  logic [B-1:0] r_dump_data;
  logic         w_dump_valid;
  logic         w_dump_busy;
  logic         w_dump_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.i_dump_start) w_next = ST_READ;
      ST_READ:  w_next = ST_VALID;
      ST_VALID: if (bus.i_dump_ready) w_next = (r_dump_idx == C_LAST) ? ST_DONE : ST_READ;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_dump_valid = (r_state == ST_VALID);
    w_dump_busy  = (r_state != ST_IDLE);
    w_dump_done  = (r_state == ST_DONE);
  end

  // Index wraps to 0 on the final acceptance, leaving the port idle-clean.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dump_idx  <= '0;
      r_dump_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE:  if (bus.i_dump_start) r_dump_idx <= '0;
        ST_READ:  r_dump_data <= mem[r_dump_idx];
        ST_VALID: if (bus.i_dump_ready) r_dump_idx <= r_dump_idx + 1'b1;
        default:  ;
      endcase
    end
  end

  assign bus.o_dump_valid = w_dump_valid;
  assign bus.o_dump_busy  = w_dump_busy;
  assign bus.o_dump_done  = w_dump_done;
  assign bus.o_dump_data  = r_dump_data;
  assign bus.o_dump_addr  = r_dump_idx;
`else
  logic w_unused_dump;
  assign w_unused_dump    = bus.i_dump_start ^ bus.i_dump_ready;
  assign bus.o_dump_valid = 1'b0;
  assign bus.o_dump_busy  = 1'b0;
  assign bus.o_dump_done  = 1'b0;
  assign bus.o_dump_data  = '0;
  assign bus.o_dump_addr  = '0;
`endif

endmodule

`default_nettype wire
